sample_mul_acc_pipe: RTL
========================

SAMPLE_MUL_ACC_PIPE -- requirements
Module: sample_mul_acc_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 11: signed width of din0 (2..32).
REQ-002 SHALL have parameter DIN1_WIDTH, default 11: signed width of din1 (2..32).
REQ-003 SHALL have parameter DOUT_WIDTH, default 11: signed width of dout (2..64).
REQ-004 SHALL have parameter NUM_STAGE, default 3: pipeline depth in register stages (1..8).
REQ-005 SHALL have parameter SAT_MODE, default 0: 0 = wrap (keep low bits), 1 = signed saturate.
REQ-006 SHALL have parameter ACC_GUARD, default 8: accumulator guard bits above the full product width.
REQ-007 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-010 SHALL have port in_ready, output, 1 bit: operand pair accepted this cycle if in_valid.
REQ-011 SHALL have port din0, input, DIN0_WIDTH bits: signed operand A.
REQ-012 SHALL have port din1, input, DIN1_WIDTH bits: signed operand B.
REQ-013 SHALL have port acc_en, input, 1 bit: sampled with operands; 1 = accumulate, 0 = plain multiply.
REQ-014 SHALL have port acc_clr, input, 1 bit: sampled with operands; with acc_en, accumulator restarts from this product.
REQ-015 SHALL have port out_valid, output, 1 bit: result present on dout.
REQ-016 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-017 SHALL have port dout, output, DOUT_WIDTH bits: signed result.
REQ-018 SHALL have port ovf, output, 1 bit: the current dout did not fit DOUT_WIDTH (wrapped or saturated).

Function
REQ-019 SHALL define P = DIN0_WIDTH+DIN1_WIDTH and compute the exact signed product in P bits.
REQ-020 SHALL hold an internal accumulator of P+ACC_GUARD bits that wraps in two's complement, with no internal saturation.
REQ-021 SHALL accept a transaction on a rising edge where in_valid=1 and in_ready=1; the transaction carries din0, din1, acc_en and acc_clr.
REQ-022 SHALL drive in_ready = ~out_valid | out_ready (global stall); the whole pipeline advances only when in_ready=1.
REQ-023 SHALL insert a bubble (valid=0) into stage 1 when the pipeline advances with in_valid=0.
REQ-024 SHALL present the result with out_valid=1 exactly NUM_STAGE advancing edges after the accepting edge, with the accepting edge counted as the first.
REQ-025 SHALL update the accumulator only when a valid transaction enters the final stage:
- acc_en=1, acc_clr=1: acc = product
- acc_en=1, acc_clr=0: acc = acc + product (sign-extended)
- acc_en=0: acc unchanged
REQ-026 SHALL form the pre-resize value V as the new acc when acc_en=1, else the sign-extended product.
REQ-027 SHALL resize V to DOUT_WIDTH as follows:
- SAT_MODE=0: low DOUT_WIDTH bits
- SAT_MODE=1: clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]
REQ-028 SHALL set ovf=1 exactly when V lies outside the DOUT_WIDTH signed range, registered with dout.
REQ-029 SHALL, if DOUT_WIDTH >= P+ACC_GUARD, sign-extend V and hold ovf at 0.
REQ-030 SHALL hold dout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-031 SHALL sustain one result per cycle, in accept order, with no loss or duplication, when out_ready=1 continuously.
REQ-032 SHALL, when a result is accepted and a new one arrives on the same edge, replace it with no bubble.

Reset
REQ-033 SHALL, while ap_rst_n=0, clear all stage valid bits, the accumulator, dout and ovf to 0, and drive out_valid=0 and in_ready=1.
REQ-034 SHALL discard all in-flight transactions when reset asserts mid-operation; the first result after release comes from a post-reset accept.
REQ-035 SHALL accept a transaction on the first rising edge after ap_rst_n deasserts.

Verification
REQ-036 SHALL be tested with defaults, 30 x -20, out_ready=1 -> dout=-600, ovf=0, out_valid high exactly 3 cycles after the accept cycle.
REQ-037 SHALL be tested with 100 x 100, and with -1024 x -1024 -> with SAT_MODE=0, 100 x 100 gives dout=-240, ovf=1; with SAT_MODE=1, both give dout=1023, ovf=1.
REQ-038 SHALL be tested with accumulate 10x10 (acc_clr=1), 10x10, 10x10, then -5x4 (acc_en=0) -> dout 100, 200, 300, -20; a following 1x1 with acc_en=1, acc_clr=0 gives 301.
REQ-039 SHALL be tested with a stream of 8 back-to-back pairs and out_ready low for 5 cycles mid-stream -> in_ready low throughout the stall, dout frozen, all 8 results delivered in order.
REQ-040 SHALL be tested with reset pulsed while 2 transactions are in flight -> out_valid=0 and acc=0 at release, and no stale result ever appears.
REQ-041 SHALL be tested with NUM_STAGE=1 and NUM_STAGE=8 -> latency 1 and 8 cycles, full throughput with out_ready=1.

Source files
------------

// File: rtl/sample_mul_acc_pipe.sv
// Pipelined signed multiply-accumulate with a global valid/ready stall.
// Optional wrap or saturating resize of the result to DOUT_WIDTH.
module sample_mul_acc_pipe #(
  parameter int DIN0_WIDTH = 11,
  parameter int DIN1_WIDTH = 11,
  parameter int DOUT_WIDTH = 11,
  parameter int NUM_STAGE  = 3,
  parameter int SAT_MODE   = 0,
  parameter int ACC_GUARD  = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIN0_WIDTH-1:0]        din0,
  input  logic [DIN1_WIDTH-1:0]        din1,
  input  logic                         acc_en,
  input  logic                         acc_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int P = DIN0_WIDTH + DIN1_WIDTH;
  localparam int A = P + ACC_GUARD;

  typedef struct packed {
    logic         v;
    logic         en;
    logic         clr;
    logic [P-1:0] p;
  } stg_t;

  logic signed [P-1:0] a_x;
  logic signed [P-1:0] b_x;
  stg_t                s_in;
  stg_t                s_hd;

  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    a_x = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
    b_x = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
    s_in.v   = in_valid;
    s_in.en  = acc_en;
    s_in.clr = acc_clr;
    s_in.p   = a_x * b_x;
  end

  // Stages 1..NUM_STAGE-1 carry the product; the last stage is the output register.
  if (NUM_STAGE == 1) begin : g_nopipe
    assign s_hd = s_in;
  end else begin : g_pipe
    stg_t q [NUM_STAGE-1];
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NUM_STAGE-1; i++) q[i] <= '0;
      end else if (in_ready) begin
        q[0] <= s_in;
        for (int i = 1; i < NUM_STAGE-1; i++) q[i] <= q[i-1];
      end
    end
    assign s_hd = q[NUM_STAGE-2];
  end

  logic signed [A-1:0]          acc_q;
  logic signed [A-1:0]          pe;
  logic signed [A-1:0]          acc_new;
  logic signed [A-1:0]          v_pre;
  logic        [DOUT_WIDTH-1:0] res;
  logic                         ovf_n;

  always_comb begin
    pe      = A'($signed(s_hd.p));
    acc_new = s_hd.clr ? pe : acc_q + pe;
    v_pre   = s_hd.en ? acc_new : pe;
  end

  if (DOUT_WIDTH >= A) begin : g_ext
    always_comb begin
      res   = DOUT_WIDTH'(v_pre);
      ovf_n = 1'b0;
    end
  end else begin : g_rsz
    logic [A-DOUT_WIDTH:0] hi;
    logic                  fits;
    // Fits when every bit from the dout sign bit upward agrees.
    always_comb begin
      hi    = v_pre[A-1:DOUT_WIDTH-1];
      fits  = (&hi) | ~(|hi);
      ovf_n = ~fits;
      res   = v_pre[DOUT_WIDTH-1:0];
      if (SAT_MODE != 0 && !fits)
        res = v_pre[A-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                         : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      acc_q     <= '0;
    end else if (in_ready) begin
      out_valid <= s_hd.v;
      if (s_hd.v) begin
        dout <= res;
        ovf  <= ovf_n;
        if (s_hd.en) acc_q <= acc_new;
      end
    end
  end

endmodule
